// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter
// and the display stages that consume its output.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) digit_o = digit_i + BCD_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, N shifts per
// conversion, result and overflow registered on entry to DONE.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned N      = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = BCD_W * (DIGITS + 1);
  localparam int unsigned OW = BCD_W * DIGITS;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   scr_q, scr_d, scr_adj;
  logic [N-1:0]    bin_q, bin_d;
  logic [OW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scr_q[g*BCD_W +: BCD_W]),
      .digit_o (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scr_q   <= scr_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // SHIFT lingers one cycle with the counter at zero; that cycle loads the
  // result registers so they are already valid while done is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scr_d   = scr_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(N);
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          {scr_d, bin_d} = {scr_adj[SW-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
          bcd_d   = scr_q[OW-1:0];
          ovf_d   = |scr_q[SW-1 -: BCD_W];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    bcd_out  = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and random checks of bin_to_bcd_seq: results via a scoreboard,
// busy/done timing every cycle, start-ignore and reset-abort behaviour.
module tb_bin_to_bcd_seq;

  localparam int N_W = 14;
  localparam int DG  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [N_W-1:0] bin_in;
  logic          busy;
  logic          done;
  logic [4*DG-1:0] bcd_out;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  logic [16:0] sb[$];
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_seq #(.N(N_W), .DIGITS(DG)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int unsigned v);
    logic [15:0] b;
    int unsigned r;
    r = v % 10000;
    for (int i = 0; i < 4; i++) begin
      b[i*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return {(v > 9999), b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enters and leaves on a falling edge. pulse_a/pulse_b: negedge index (after
  // the start edge) at which start is re-raised with 777; rst_at: negedge index
  // at which reset is raised for one cycle. -1 disables each.
  task automatic run_conv(input int unsigned v, input int pulse_a, input int pulse_b,
                          input int rst_at);
    bit aborted;
    logic exp_busy, exp_done;
    aborted = (rst_at >= 0);
    bin_in  = N_W'(v);
    start   = 1'b1;
    if (!aborted) sb.push_back(model(v));
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~N_W'(v);
    for (int n = 0; n <= N_W + 3; n++) begin
      @(negedge clk);
      exp_busy = aborted ? (n <= rst_at) : (n <= N_W + 1);
      exp_done = !aborted && (n == N_W + 1);
      check($sformatf("busy v=%0d n=%0d", v, n), 32'(busy), 32'(exp_busy));
      check($sformatf("done v=%0d n=%0d", v, n), 32'(done), 32'(exp_done));
      if (n == N_W / 2 && (!aborted || n <= rst_at)) begin
        check("bcd_hold", 32'(bcd_out), 32'(last_bcd));
        check("ovf_hold", 32'(overflow), 32'(last_ovf));
      end
      if (aborted && n == rst_at + 1) begin
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        last_bcd = '0;
        last_ovf = 1'b0;
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'(1), 32'(0));
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          check($sformatf("bcd v=%0d", v), 32'(bcd_out), 32'(e[15:0]));
          check($sformatf("ovf v=%0d", v), 32'(overflow), 32'(e[16]));
          last_bcd = e[15:0];
          last_ovf = e[16];
        end
      end
      start = (n == pulse_a || n == pulse_b);
      if (start) bin_in = N_W'(777);
      reset = (n == rst_at);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bin_in   = '0;
    last_bcd = '0;
    last_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_bcd", 32'(bcd_out), 32'h0);
    check("reset_ovf", 32'(overflow), 32'h0);

    run_conv(0, -1, -1, -1);
    run_conv(1234, -1, -1, -1);
    run_conv(9999, -1, -1, -1);
    run_conv(16383, -1, -1, -1);
    run_conv(10000, -1, -1, -1);
    run_conv(42, 4, N_W + 1, -1);
    run_conv(5555, -1, -1, 6);
    run_conv(5555, -1, -1, -1);
    run_conv(1, -1, -1, -1);
    run_conv(10, -1, -1, -1);
    for (int i = 0; i < 40; i++) run_conv($urandom_range(0, 16383), -1, -1, -1);

    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
